// File: rtl/approx_mult_pkg.sv
// Shared types and widths for the sequential approximate multiplier.
package approx_mult_pkg;

   localparam int DATA_W = 16;
   localparam int PROD_W = 32;
   localparam int IDX_W  = 4;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Weight a partial-product row by its multiplier bit position.
   function automatic logic [PROD_W-1:0] weight_row(input logic [DATA_W-1:0] row,
                                                    input logic [IDX_W-1:0]  pos);
      return PROD_W'(row) << pos;
   endfunction

endpackage

// File: rtl/pp_row_reg.sv
// 16x1 AND partial-product row with its output register; one cycle from sel to pp_q.
module pp_row_reg
   import approx_mult_pkg::*;
(
   input  logic              clk,
   input  logic [DATA_W-1:0] a,
   input  logic              sel,
   output logic [DATA_W-1:0] pp_q
);

   always_ff @(posedge clk) begin
      pp_q <= a & {DATA_W{sel}};
   end

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// Shift-add sequencer around pp_row_reg; 18-cycle latency, or 18-APPROX_ROWS with APPROX_ROWS_EN.
// APPROX_ROWS_EN skips the low APPROX_ROWS multiplier bits; the result is held in DONE until out_ready.
module approx_mult_seq_ctrl
   import approx_mult_pkg::*;
#(
   parameter int APPROX_ROWS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] p
);

`ifdef APPROX_ROWS_EN
   localparam logic APPROX_ON = 1'b1;
`else
   localparam logic APPROX_ON = 1'b0;
`endif

   localparam logic [IDX_W-1:0] FIRST = APPROX_ON ? IDX_W'(APPROX_ROWS) : '0;

   state_t              state;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_d;
   logic                pp_vld;
   logic [DATA_W-1:0]   pp_q;
   logic [PROD_W-1:0]   acc;
   logic [PROD_W-1:0]   acc_next;

   pp_row_reg u_row (
      .clk  (clk),
      .a    (a_q),
      .sel  (b_q[idx]),
      .pp_q (pp_q)
   );

   // pp_q lags the bit select by a cycle, so it is weighted with idx_d.
   assign acc_next = acc + weight_row(pp_q, idx_d);

   assign in_ready  = (state == IDLE) & ~rst;
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) | (state == FLUSH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         idx_d  <= '0;
         pp_vld <= 1'b0;
         acc    <= '0;
         p      <= '0;
      end else begin
         if (pp_vld) begin
            acc <= acc_next;
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q    <= a;
                  b_q    <= b;
                  idx    <= FIRST;
                  acc    <= '0;
                  pp_vld <= 1'b0;
                  state  <= RUN;
               end
            end
            RUN: begin
               idx_d  <= idx;
               pp_vld <= 1'b1;
               idx    <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               pp_vld <= 1'b0;
               p      <= acc_next;
               state  <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// Scoreboard bench for approx_mult_seq_ctrl; expectations follow the build's APPROX_ROWS_EN setting.
module tb_approx_mult_seq_ctrl;

   localparam int ROWS = 4;
`ifdef APPROX_ROWS_EN
   localparam int FIRST = ROWS;
`else
   localparam int FIRST = 0;
`endif
   localparam int LAT = 18 - FIRST;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] p;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] sb_q[$];

   approx_mult_seq_ctrl #(.APPROX_ROWS(ROWS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] mask;
      mask = 16'hFFFF << FIRST;
      return 32'(x) * 32'(y & mask);
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                         input int hold, input bit poke_busy);
      int t0;
      int n;
      logic [31:0] p0;
      logic [31:0] exp;
      @(negedge clk);
      wait_ready();
      in_valid = 1'b1;
      a = x;
      b = y;
      t0 = cyc;
      sb_q.push_back(model(x, y));
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_run", 32'(busy), 32'd1);
      if (poke_busy) begin
         in_valid = 1'b1;
         a = 16'h00FF;
         b = 16'h00FF;
         check("in_ready_run", 32'(in_ready), 32'd0);
         @(negedge clk);
         in_valid = 1'b0;
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (out_valid !== 1'b1) begin
         check("out_valid_timeout", 32'(out_valid), 32'd1);
         return;
      end
      check("latency", 32'(cyc - t0), 32'(LAT));
      check("busy_done", 32'(busy), 32'd0);
      p0 = p;
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_p", p, p0);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      exp = sb_q.pop_front();
      check("product", p, exp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_after", 32'(in_ready), 32'd1);
      check("out_valid_after", 32'(out_valid), 32'd0);
      check("p_retained", p, exp);
   endtask

   initial begin
      int t0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p", p, 32'd0);
      rst = 1'b0;
      #1;
      check("in_ready_post_rst", 32'(in_ready), 32'd1);

      run_op(16'h0003, 16'h0005, 0, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 5, 1'b0);
      run_op(16'h1234, 16'h0010, 0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         run_op(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)), k, 1'b0);
      end

      // Abort an operation on its 6th RUN cycle.
      @(negedge clk);
      wait_ready();
      in_valid = 1'b1;
      a = 16'hABCD;
      b = 16'h1357;
      t0 = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready_rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_cycles", 32'(cyc - t0), 32'd7);
      run_op(16'h0002, 16'h0007, 1, 1'b0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
